if_pc_ctrl: RTL and testbench

- Parametrised fetch program-counter controller for the RISC-V core.
- Holds the PC and issues fetch requests to instruction memory through a valid/ready handshake.
- Sequential advance, redirect (branch/jump) and trap vectoring are prioritised.
- Misaligned redirect targets are detected and held in a fault state until a trap resolves them.
- Replaces the plain PC register at the IF stage for both single-cycle and pipelined builds.

---
 rtl/if_pc_ctrl.sv | 89 ++++++++
 tb/tb_if_pc_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/if_pc_ctrl.sv
// Fetch program-counter controller for the IF stage: holds the PC, issues fetch requests and
// prioritises trap vectoring over redirects over sequential advance.
module if_pc_ctrl #(
    parameter int unsigned          XLEN       = 32,
    parameter logic [XLEN-1:0]      RESET_PC   = '0,
    parameter int unsigned          STEP       = 4,
    parameter int unsigned          ALIGN_BITS = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_i,
    input  logic [XLEN-1:0] trap_vec_i,
    input  logic            req_ready_i,
    output logic            req_valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_seq_o,
    output logic            fire_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] AlignMask = ~({XLEN{1'b1}} << ALIGN_BITS);
    localparam logic [XLEN-1:0] StepVal   = XLEN'(STEP);

    typedef enum logic [1:0] {StBoot, StRun, StFault} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic            redirect_misaligned;

    assign redirect_misaligned = |(redirect_pc_i & AlignMask);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state and PC selection
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        misalign_d = misalign_q;
        if (trap_i) begin
            pc_d       = trap_vec_i & ~AlignMask;
            state_d    = StRun;
            misalign_d = 1'b0;
        end else if (redirect_i && (state_q != StFault)) begin
            // Misaligned target is kept unmodified so the trap handler can report it.
            pc_d = redirect_pc_i;
            if (redirect_misaligned) begin
                state_d    = StFault;
                misalign_d = 1'b1;
            end else begin
                state_d = StRun;
            end
        end else if (fire_o) begin
            pc_d = pc_seq_o;
        end else if (state_q == StBoot) begin
            state_d = StRun;
        end
    end

    // Outputs
    always_comb begin
        req_valid_o = 1'b0;
        unique case (state_q)
            StBoot:  req_valid_o = 1'b0;
            StRun:   req_valid_o = !stall_i;
            StFault: req_valid_o = 1'b0;
            default: req_valid_o = 1'b0;
        endcase
        fire_o     = req_valid_o & req_ready_i;
        pc_o       = pc_q;
        pc_seq_o   = pc_q + StepVal;
        misalign_o = misalign_q;
    end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Scoreboard bench for if_pc_ctrl: expected post-edge PC/fault state is queued when inputs are
// driven and compared after the edge; combinational outputs are checked in the same cycle.
module tb_if_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n;
    logic        stall_i, redirect_i, trap_i, req_ready_i;
    logic [31:0] redirect_pc_i, trap_vec_i;

    logic        valid1, fire1, mis1, valid2, fire2, mis2;
    logic [31:0] pc1, seq1, pc2, seq2;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          sel = 1'b0;
    logic [31:0] cur_pc;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        mis;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    if_pc_ctrl #(
        .XLEN(32), .RESET_PC(32'h0000_0000), .STEP(4), .ALIGN_BITS(2)
    ) u_dut (
        .clk(clk), .rst_n(rst1_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .req_ready_i(req_ready_i), .req_valid_o(valid1), .pc_o(pc1), .pc_seq_o(seq1),
        .fire_o(fire1), .misalign_o(mis1)
    );

    if_pc_ctrl #(
        .XLEN(32), .RESET_PC(32'h8000_0000), .STEP(4), .ALIGN_BITS(1)
    ) u_dut_hi (
        .clk(clk), .rst_n(rst2_n), .stall_i(stall_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .trap_i(trap_i), .trap_vec_i(trap_vec_i),
        .req_ready_i(req_ready_i), .req_valid_o(valid2), .pc_o(pc2), .pc_seq_o(seq2),
        .fire_o(fire2), .misalign_o(mis2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic compare_pending();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, "/pc"}, sel ? pc2 : pc1, e.pc);
        check({e.tag, "/misalign"}, {31'd0, sel ? mis2 : mis1}, {31'd0, e.mis});
        cur_pc = e.pc;
    endtask

    task automatic do_reset(input logic [31:0] rst_pc);
        @(negedge clk);
        if (sel) rst2_n = 1'b0; else rst1_n = 1'b0;
        stall_i = 0; redirect_i = 0; trap_i = 0; req_ready_i = 0;
        redirect_pc_i = '0; trap_vec_i = '0;
        @(posedge clk);
        @(posedge clk);
        sb_q.push_back('{"reset", rst_pc, 1'b0});
    endtask

    task automatic drive(input string tag, input logic rst, input logic stall, input logic redir,
                         input logic [31:0] rpc, input logic trap, input logic [31:0] tvec,
                         input logic ready, input logic exp_valid, input logic [31:0] exp_pc,
                         input logic exp_mis);
        @(negedge clk);
        compare_pending();
        if (sel) rst2_n = rst; else rst1_n = rst;
        stall_i = stall; redirect_i = redir; redirect_pc_i = rpc;
        trap_i = trap; trap_vec_i = tvec; req_ready_i = ready;
        #1;
        check({tag, "/valid"}, {31'd0, sel ? valid2 : valid1}, {31'd0, exp_valid});
        check({tag, "/fire"}, {31'd0, sel ? fire2 : fire1}, {31'd0, exp_valid & ready});
        check({tag, "/pc_seq"}, sel ? seq2 : seq1, cur_pc + 32'd4);
        sb_q.push_back('{tag, exp_pc, exp_mis});
    endtask

    initial begin
        rst1_n = 1'b0; rst2_n = 1'b0; cur_pc = '0;
        // tag, rst, stall, redir, rpc, trap, tvec, ready, exp_valid, exp_pc, exp_mis
        do_reset(32'h0);
        drive("boot",      1, 0, 0, 32'h0,         0, 32'h0,    1, 0, 32'h0,         0);
        drive("run0",      1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h4,         0);
        drive("run4",      1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h8,         0);
        drive("run8",      1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'hC,         0);
        drive("to100",     1, 0, 1, 32'h100,       0, 32'h0,    0, 1, 32'h100,       0);
        for (int i = 0; i < 3; i++)
            drive("bp",    1, 0, 0, 32'h0,         0, 32'h0,    0, 1, 32'h100,       0);
        drive("stall",     1, 1, 0, 32'h0,         0, 32'h0,    1, 0, 32'h100,       0);
        drive("release",   1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h104,       0);
        drive("to200",     1, 0, 1, 32'h200,       0, 32'h0,    0, 1, 32'h200,       0);
        drive("redir_fire",1, 0, 1, 32'h80,        0, 32'h0,    1, 1, 32'h80,        0);
        drive("misalign",  1, 0, 1, 32'h82,        0, 32'h0,    0, 1, 32'h82,        1);
        drive("fault_ign", 1, 0, 1, 32'h40,        0, 32'h0,    1, 0, 32'h82,        1);
        drive("fault_trap",1, 0, 0, 32'h0,         1, 32'h1003, 0, 0, 32'h1000,      0);
        drive("post_trap", 1, 0, 0, 32'h0,         0, 32'h0,    0, 1, 32'h1000,      0);
        drive("trap_prio", 1, 0, 1, 32'h400,       1, 32'h300,  1, 1, 32'h300,       0);
        drive("to_top",    1, 0, 1, 32'hFFFF_FFFC, 0, 32'h0,    0, 1, 32'hFFFF_FFFC, 0);
        drive("wrap",      1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h0,         0);
        drive("to500",     1, 0, 1, 32'h500,       0, 32'h0,    0, 1, 32'h500,       0);
        drive("mid_rst",   0, 1, 1, 32'h600,       0, 32'h0,    1, 0, 32'h0,         0);
        drive("boot_trap", 1, 0, 0, 32'h0,         1, 32'h703,  1, 0, 32'h700,       0);
        drive("run700",    1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h704,       0);
        drive("idle",      1, 1, 0, 32'h0,         0, 32'h0,    1, 0, 32'h704,       0);
        @(negedge clk);
        compare_pending();

        sel = 1'b1;
        do_reset(32'h8000_0000);
        drive("hi_boot",   1, 0, 0, 32'h0,         0, 32'h0,    0, 0, 32'h8000_0000, 0);
        drive("hi_run",    1, 0, 0, 32'h0,         0, 32'h0,    1, 1, 32'h8000_0004, 0);
        drive("hi_half",   1, 1, 1, 32'h8000_0002, 0, 32'h0,    1, 0, 32'h8000_0002, 0);
        drive("hi_rst",    0, 1, 1, 32'h8000_0010, 0, 32'h0,    1, 0, 32'h8000_0000, 0);
        drive("hi_boot2",  1, 0, 0, 32'h0,         0, 32'h0,    1, 0, 32'h8000_0000, 0);
        @(negedge clk);
        compare_pending();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
